// File: rtl/eaglesong_nonce_scheduler_pkg.sv
// Shared types and sizes for the Eaglesong nonce scheduler.
package eaglesong_sched_pkg;

  localparam int unsigned MSG_LEN_BYTES = 32;
  localparam int unsigned HEADER_BYTES  = 24;
  localparam int unsigned NONCE_W       = 64;
  localparam int unsigned HEADER_W      = HEADER_BYTES * 8;
  localparam int unsigned MSG_W         = MSG_LEN_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4,
    ST_DRAIN  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/eaglesong_nonce_scheduler_target_cmp.sv
// Combinational 256-bit unsigned less-than between a digest and the job target.
module eaglesong_target_cmp
  import eaglesong_sched_pkg::*;
(
  input  logic [MSG_W-1:0] digest,
  input  logic [MSG_W-1:0] target,
  output logic             hit
);

  always_comb begin
    hit = (digest < target);
  end

endmodule

// File: rtl/eaglesong_nonce_scheduler.sv
// Sequences one Eaglesong digest core across a nonce range and reports digests below target.
module eaglesong_nonce_scheduler
  import eaglesong_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [HEADER_W-1:0] job_header,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [31:0]         job_nonce_count,
  input  logic [MSG_W-1:0]    job_target,
  input  logic                abort,
  output logic [MSG_W-1:0]    core_input_val,
  output logic [6:0]          core_input_length_bytes,
  output logic                core_start_eval,
  input  logic [MSG_W-1:0]    core_output_val,
  input  logic                core_eval_output_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [MSG_W-1:0]    res_hash,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [31:0]         hashes_done
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t        state_q, state_d;
  logic [HEADER_W-1:0] header_q, header_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [MSG_W-1:0]    target_q, target_d;
  logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                rdy_prev_q, rdy_prev_d;
  logic                res_valid_q, res_valid_d;
  logic [NONCE_W-1:0]  res_nonce_q, res_nonce_d;
  logic [MSG_W-1:0]    res_hash_q, res_hash_d;
  logic                done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [31:0]         hashes_done_q, hashes_done_d;

  logic hit;
  logic ready_rise;
  logic tmo_last;
  logic advance;

  eaglesong_target_cmp u_target_cmp (
    .digest (core_output_val),
    .target (target_q),
    .hit    (hit)
  );

  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    nonce_d       = nonce_q;
    remaining_d   = remaining_q;
    target_d      = target_q;
    tmo_cnt_d     = tmo_cnt_q;
    rdy_prev_d    = core_eval_output_ready;
    res_valid_d   = res_valid_q;
    res_nonce_d   = res_nonce_q;
    res_hash_d    = res_hash_q;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    hashes_done_d = hashes_done_q;
    advance       = 1'b0;
    ready_rise    = core_eval_output_ready && !rdy_prev_q;
    tmo_last      = (tmo_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          header_d      = job_header;
          nonce_d       = job_nonce_start;
          remaining_d   = job_nonce_count;
          target_d      = job_target;
          hashes_done_d = '0;
          if (job_nonce_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready edge arriving on the last allowed cycle still counts as a result.
        if (ready_rise) begin
          state_d = ST_CHECK;
        end else if (tmo_last) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (hashes_done_q != '1) begin
          hashes_done_d = hashes_done_q + 1'b1;
        end
        if (hit) begin
          res_valid_d = 1'b1;
          res_nonce_d = nonce_q;
          res_hash_d  = core_output_val;
          state_d     = ST_REPORT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          advance     = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ready_rise || tmo_last) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (remaining_q == 32'd1) begin
        remaining_d = '0;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        remaining_d = remaining_q - 1'b1;
        nonce_d     = nonce_q + 1'b1;
        state_d     = ST_ISSUE;
      end
    end

    // Abort overrides the case above; a core still hashing must be drained first
    // so its late digest is not credited to the next job.
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ((state_q == ST_WAIT) && !ready_rise) ? ST_DRAIN : ST_IDLE;
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      res_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      header_q      <= '0;
      nonce_q       <= '0;
      remaining_q   <= '0;
      target_q      <= '0;
      tmo_cnt_q     <= '0;
      rdy_prev_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_nonce_q   <= '0;
      res_hash_q    <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      hashes_done_q <= '0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      nonce_q       <= nonce_d;
      remaining_q   <= remaining_d;
      target_q      <= target_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rdy_prev_q    <= rdy_prev_d;
      res_valid_q   <= res_valid_d;
      res_nonce_q   <= res_nonce_d;
      res_hash_q    <= res_hash_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      hashes_done_q <= hashes_done_d;
    end
  end

  always_comb begin
    busy                    = (state_q != ST_IDLE);
    job_ready               = (state_q == ST_IDLE) && !rst;
    core_start_eval         = (state_q == ST_ISSUE);
    core_input_val          = {nonce_q, header_q};
    core_input_length_bytes = busy ? 7'(MSG_LEN_BYTES) : '0;
    res_valid               = res_valid_q;
    res_nonce               = res_nonce_q;
    res_hash                = res_hash_q;
    done                    = done_q;
    timeout_err             = timeout_err_q;
    hashes_done             = hashes_done_q;
  end

endmodule

// File: tb/tb_eaglesong_nonce_scheduler.sv
// Directed bench for eaglesong_nonce_scheduler with a behavioural 40-cycle digest core model.
module tb_eaglesong_nonce_scheduler;

  localparam int unsigned TMO = 50;
  localparam int unsigned LAT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [191:0] job_header;
  logic [63:0]  job_nonce_start;
  logic [31:0]  job_nonce_count;
  logic [255:0] job_target;
  logic         abort;
  logic [255:0] core_input_val;
  logic [6:0]   core_input_length_bytes;
  logic         core_start_eval;
  logic [255:0] core_output_val;
  logic         core_eval_output_ready;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_nonce;
  logic [255:0] res_hash;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic [31:0]  hashes_done;

  eaglesong_nonce_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .job_valid               (job_valid),
    .job_ready               (job_ready),
    .job_header              (job_header),
    .job_nonce_start         (job_nonce_start),
    .job_nonce_count         (job_nonce_count),
    .job_target              (job_target),
    .abort                   (abort),
    .core_input_val          (core_input_val),
    .core_input_length_bytes (core_input_length_bytes),
    .core_start_eval         (core_start_eval),
    .core_output_val         (core_output_val),
    .core_eval_output_ready  (core_eval_output_ready),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_nonce               (res_nonce),
    .res_hash                (res_hash),
    .busy                    (busy),
    .done                    (done),
    .timeout_err             (timeout_err),
    .hashes_done             (hashes_done)
  );

  always #5 clk = ~clk;

  // Core model: ready drops on start, rises LAT edges later unless stuck.
  logic   model_stuck = 1'b0;
  int     m_cnt = 0;
  logic   m_ready = 1'b0;
  logic [255:0] m_out = '0;
  assign core_eval_output_ready = m_ready;
  assign core_output_val        = m_out;

  always @(posedge clk) begin
    if (core_start_eval) begin
      m_ready <= 1'b0;
      m_cnt   <= LAT;
      m_out   <= {192'h0, core_input_val[255:192]};
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      if (!model_stuck) m_ready <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Event monitor.
  int start_cnt = 0, dbl_cnt = 0, done_cnt = 0, tmo_cnt = 0, rv_cnt = 0;
  int cyc = 0, rise_cyc = 0, done_cyc = 0;
  logic start_prev = 1'b0, rdy_seen = 1'b0;
  logic [63:0] issue_q[$];

  always @(posedge clk) begin
    if (core_start_eval) begin
      start_cnt++;
      issue_q.push_back(core_input_val[255:192]);
      if (start_prev) dbl_cnt++;
    end
    start_prev = core_start_eval;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (timeout_err) tmo_cnt++;
    if (res_valid) rv_cnt++;
    if (core_eval_output_ready && !rdy_seen) rise_cyc = cyc;
    rdy_seen = core_eval_output_ready;
    cyc++;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [191:0] hdr, input logic [63:0] ns, input logic [31:0] cnt,
                          input logic [255:0] tgt, output bit ok);
    ok              = 1'b0;
    job_header      = hdr;
    job_nonce_start = ns;
    job_nonce_count = cnt;
    job_target      = tgt;
    job_valid       = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (job_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_rv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    bit ok;
    int base_start, base_done, base_tmo, base_rv, base_q, n;
    logic [191:0] hdr;

    rst = 1'b1; job_valid = 1'b0; job_header = '0; job_nonce_start = '0;
    job_nonce_count = '0; job_target = '0; abort = 1'b0; res_ready = 1'b0;
    hdr = 192'h1817161514131211_0807060504030201_F0E0D0C0B0A09080;

    // Reset
    tick(); tick(); tick();
    check("rst_job_ready", job_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_len", core_input_length_bytes, 0);
    check("rst_outs", {res_valid, done, timeout_err, core_start_eval}, 0);
    check("rst_hashes", hashes_done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_job_ready", job_ready, 1);

    // Hits with backpressure: nonces 0..5, target 3
    base_start = start_cnt; base_done = done_cnt;
    send_job('0, 64'd0, 32'd6, 256'd3, ok);
    check("t1_accept", ok, 1);
    check("t1_start_after_accept", core_start_eval, 1);
    check("t1_len_busy", core_input_length_bytes, 7'd32);
    check("t1_job_ready_busy", job_ready, 0);
    for (int h = 0; h < 3; h++) begin
      wait_rv(ok);
      check("t1_rv_seen", ok, 1);
      check("t1_res_nonce", res_nonce, h);
      check("t1_res_hash", res_hash, h);
      tick(); tick();
      check("t1_rv_hold", res_valid, 1);
      check("t1_nonce_hold", res_nonce, h);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("t1_rv_drop", res_valid, 0);
    end
    wait_done(ok);
    check("t1_done_seen", ok, 1);
    check("t1_hashes", hashes_done, 6);
    check("t1_no_rv_at_done", res_valid, 0);
    tick();
    check("t1_done_width", done, 0);
    check("t1_idle", busy, 0);
    check("t1_done_cnt", done_cnt - base_done, 1);
    check("t1_starts", start_cnt - base_start, 6);
    check("t1_start_width", dbl_cnt, 0);
    check("t1_done_gap", done_cyc - rise_cyc, 2);

    // Zero count
    base_start = start_cnt; base_done = done_cnt;
    send_job('0, 64'd7, 32'd0, 256'd3, ok);
    check("t2_accept", ok, 1);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_no_start", core_start_eval, 0);
    check("t2_hashes_cleared", hashes_done, 0);
    tick();
    check("t2_done_width", done, 0);
    check("t2_starts", start_cnt - base_start, 0);
    check("t2_done_cnt", done_cnt - base_done, 1);

    // Nonce wrap, res_ready held high
    res_ready = 1'b1;
    base_q = issue_q.size(); base_rv = rv_cnt;
    send_job('0, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 256'd2, ok);
    check("t3_accept", ok, 1);
    wait_rv(ok);
    check("t3_rv_seen", ok, 1);
    check("t3_res_nonce", res_nonce, 0);
    check("t3_res_hash", res_hash, 0);
    wait_done(ok);
    check("t3_done_seen", ok, 1);
    tick();
    check("t3_nonce0", issue_q[base_q], 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3_nonce1", issue_q[base_q+1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_nonce2", issue_q[base_q+2], 64'h0);
    check("t3_one_report_cycle", rv_cnt - base_rv, 1);
    check("t3_hashes", hashes_done, 3);
    res_ready = 1'b0;

    // Abort during WAIT, then a fresh job must not see the stale digest
    base_done = done_cnt; base_tmo = tmo_cnt;
    send_job('0, 64'd100, 32'd5, 256'd0, ok);
    check("t4_accept", ok, 1);
    tick();
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_draining", busy, 1);
    check("t4_drain_no_start", core_start_eval, 0);
    wait_idle(ok);
    check("t4_idle", ok, 1);
    check("t4_drain_follows_edge", core_eval_output_ready, 1);
    check("t4_no_done", done_cnt - base_done, 0);
    check("t4_no_tmo", tmo_cnt - base_tmo, 0);
    send_job(hdr, 64'd200, 32'd1, '1, ok);
    check("t4_accept2", ok, 1);
    check("t4_packing", core_input_val, {64'd200, hdr});
    check("t4_hashes_cleared", hashes_done, 0);
    wait_rv(ok);
    check("t4_rv_seen", ok, 1);
    check("t4_res_nonce", res_nonce, 64'd200);
    check("t4_res_hash", res_hash, 256'd200);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_done(ok);
    check("t4_done_seen", ok, 1);
    tick();

    // Stuck core: timeout
    model_stuck = 1'b1;
    base_done = done_cnt; base_tmo = tmo_cnt;
    send_job('0, 64'd5, 32'd2, '1, ok);
    check("t5_accept", ok, 1);
    tick();
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    check("t5_tmo_latency", n, TMO);
    check("t5_job_ready", job_ready, 1);
    tick();
    check("t5_tmo_width", timeout_err, 0);
    check("t5_tmo_cnt", tmo_cnt - base_tmo, 1);
    check("t5_no_done", done_cnt - base_done, 0);
    model_stuck = 1'b0;

    // Reset mid-job
    base_done = done_cnt;
    send_job('0, 64'd9, 32'd3, '1, ok);
    check("t6_accept", ok, 1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_job_ready_in_rst", job_ready, 0);
    check("t6_len", core_input_length_bytes, 0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 10; i++) tick();
    check("t6_stays_idle", busy, 0);
    check("t6_no_rv", res_valid, 0);
    check("t6_no_done", done_cnt - base_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eaglesong_nonce_scheduler.md
# eaglesong_nonce_scheduler

Job controller that sequences one `eaglesong_digest_top` core across a nonce range. It accepts a mining job (24-byte header, start nonce, nonce count, 256-bit target) and, for each nonce, packs a 32-byte message and pulses the core. It waits for each result, compares the digest against the target and reports hits through a valid/ready result port. It sits between the host job interface and the digest core; a top-level wrapper instantiates both.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 120: maximum WAIT cycles per digest before the job is abandoned.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  high only in IDLE and not in reset.
- `job_header`  in  192  message bytes 0..23, where byte i is [8i+7:8i].
- `job_nonce_start`  in  64  first nonce.
- `job_nonce_count`  in  32  number of nonces to hash.
- `job_target`  in  256  hit threshold.
- `abort`  in  1  cancel the current job.
- `core_input_val`  out  256  message to the core.
- `core_input_length_bytes`  out  7  constant 7'd32 while busy, 0 otherwise.
- `core_start_eval`  out  1  one-cycle start pulse.
- `core_output_val`  in  256  digest from the core.
- `core_eval_output_ready`  in  1  core done level.
- `res_valid`  out  1  hit available.
- `res_ready`  in  1  hit consumed.
- `res_nonce`  out  64  nonce of the hit.
- `res_hash`  out  256  digest of the hit.
- `busy`  out  1  state not IDLE.
- `done`  out  1  one-cycle pulse when all nonces are processed.
- `timeout_err`  out  1  one-cycle pulse on core timeout.
- `hashes_done`  out  32  digests checked in the current job; cleared on job accept.

## Operation
- **Message packing:** `core_input_val` = {nonce[63:0], header[191:0]}, so the nonce is little-endian in bytes 24..31. The value is held stable from ISSUE through CHECK.
- **States:** IDLE, ISSUE, WAIT, CHECK, REPORT, DRAIN.
- **IDLE:** on `job_valid`&&`job_ready`, latch all job fields and set remaining = count.
  - count == 0 → `done` pulse, stay in IDLE.
  - otherwise → ISSUE.
- **ISSUE:** `core_start_eval`=1 for exactly this cycle, clear the timeout counter → WAIT.
- **WAIT:** advance only on a rising edge of `core_eval_output_ready` (1 now, 0 on the previous cycle). A level already high from the previous digest is ignored.
  - rising edge → CHECK.
  - counter reaches TIMEOUT_CYCLES → `timeout_err` pulse → IDLE, no `done`.
- **CHECK:** hit = `core_output_val` < target, strict unsigned 256-bit compare. Increment `hashes_done`.
  - hit → load `res_nonce`/`res_hash` → REPORT.
  - else → advance.
- **REPORT:** hold `res_valid` and the result until `res_ready`, then advance.
- **Advance:** decrement remaining.
  - remaining reaches 0 → `done` pulse → IDLE.
  - else → nonce += 1 (mod 2^64, so 64'hFFFF_FFFF_FFFF_FFFF wraps to 0) → ISSUE.
- **abort:** takes priority over every transition.
  - from WAIT → DRAIN.
  - from any other state → IDLE next cycle.
  - `res_valid` drops the next cycle and no `done` is issued.
- **DRAIN:** wait for the core's rising edge or timeout, discard the result, → IDLE with no `done` or `timeout_err`. This prevents a stale digest being credited to the next job.
- `abort` in IDLE has no effect. `job_valid` is ignored outside IDLE.

## Timing
- **Reset:** `rst` forces IDLE and clears all outputs to 0 on the same edge; `job_ready` is 0 while `rst`=1. Applying `rst` mid-job discards the job. If the core is still running, its later ready edge is ignored because IDLE does not watch it.
- **Latency per nonce without a hit:** 1 (ISSUE) + core latency L + 1 (CHECK) cycles. For a job of N nonces with no hits, `done` fires L+2 cycles after the last ISSUE.
- **Accept to first start:** `core_start_eval` is high on the cycle after the accept edge.
- **Hit backpressure:** REPORT adds ≥1 cycle. `res_ready` already high gives exactly one REPORT cycle.
- **Simultaneous events:**
  - `abort` and `res_ready` in REPORT: abort wins, the result counts as dropped.
  - Timeout and rising edge in the same WAIT cycle: the edge wins.
- `hashes_done` saturates at 32'hFFFF_FFFF. It is unreachable in practice since count is 32-bit.

## Structure
- Package `eaglesong_sched_pkg`:
  - state enum `sched_state_t`.
  - `MSG_LEN_BYTES` = 32.
  - `HEADER_BYTES` = 24.
  - `NONCE_W` = 64.
- Sub-module `eaglesong_target_cmp`: combinational 256-bit unsigned less-than, kept separate so it can be pipelined later.
- The digest core is not instantiated here; the wrapper `eaglesong_miner_top` connects both blocks.

## Test plan
Behavioural core model: latency 40, `output_val` = {192'h0, input_val[255:192]}, ready falls on start.
- **Hits with backpressure:** header 0, start 0, count 6, target 3 → hits reported for nonces 0, 1, 2 in order with `res_hash` = nonce. `hashes_done`=6, one `done` pulse, 6 start pulses each 1 cycle wide.
- **Zero count:** count 0 → `done` the cycle after accept, no `core_start_eval`, `busy` low.
- **Nonce wrap:** start 64'hFFFF_FFFF_FFFF_FFFE, count 3, target 2 → nonces FFFE, FFFF, 0 issued. One hit at nonce 0, `core_input_val[255:192]`=0 on the third issue.
- **Abort in WAIT:** abort at cycle 10 of WAIT → DRAIN until the model's edge, then IDLE. The next job's first result is not the aborted nonce; no `done`.
- **Stuck core:** model never raises ready → `timeout_err` pulses exactly TIMEOUT_CYCLES cycles after WAIT entry, no `done`, `job_ready`=1 next cycle.
- **Real core:** real `eaglesong_digest_top`, header 0, count 2, target all-ones → 2 hits whose `res_hash` matches the software Eaglesong of the packed 32-byte messages.
